// File: rtl/puzzle_pkg.sv
// Shared types and sizing for the sliding-puzzle move sequencer.
// Optional blank tracking is enabled with PUZZLE_BLANK_TRACK_EN.
package puzzle_pkg;

    localparam int N_PATTERNS = 60;
    localparam int MAX_MOVES  = 20;
    localparam int CNT_W      = 5;
    localparam int ROM_W      = CNT_W + 2 * MAX_MOVES;

    typedef enum logic [1:0] {
        DOWN  = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        UP    = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/puzzle_blank_tracker.sv
// Blank-tile position register with move legality check (row-major 0..8).
// Instantiated by puzzle_move_sequencer only when PUZZLE_BLANK_TRACK_EN is defined.
module puzzle_blank_tracker
    import puzzle_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] init_i,
    input  logic       step_i,
    input  dir_t       dir_i,
    output logic [3:0] pos_o,
    output logic       illegal_o
);

    logic [3:0] pos_q;
    logic [3:0] pos_d;

    // A move off the board edge is flagged; the position only advances on legal moves.
    always_comb begin
        illegal_o = 1'b0;
        pos_d     = pos_q;
        unique case (dir_i)
            UP: begin
                if (pos_q < 4'd3) illegal_o = 1'b1;
                else              pos_d = pos_q - 4'd3;
            end
            DOWN: begin
                if (pos_q >= 4'd6) illegal_o = 1'b1;
                else               pos_d = pos_q + 4'd3;
            end
            LEFT: begin
                if (pos_q == 4'd0 || pos_q == 4'd3 || pos_q == 4'd6) illegal_o = 1'b1;
                else                                                 pos_d = pos_q - 4'd1;
            end
            RIGHT: begin
                if (pos_q == 4'd2 || pos_q == 4'd5 || pos_q == 4'd8) illegal_o = 1'b1;
                else                                                 pos_d = pos_q + 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= 4'd4;
        end else if (load_i) begin
            pos_q <= init_i;
        end else if (step_i && !illegal_o) begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/puzzle_move_sequencer.sv
// Fetches a solution word from the puzzle ROM and replays its moves over valid/ready.
// Define PUZZLE_BLANK_TRACK_EN to add blank-position tracking and illegal-move detection.
module puzzle_move_sequencer #(
    parameter int N_PATTERNS = 60,
    parameter int MAX_MOVES  = 20,
    parameter int IDX_W      = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [IDX_W-1:0]           pattern_idx_i,
    input  logic                       abort_i,
    output logic [IDX_W-1:0]           rom_addr_o,
    input  logic [5+2*MAX_MOVES-1:0]   rom_data_i,
    output logic                       move_valid_o,
    output logic [1:0]                 move_dir_o,
    input  logic                       move_ready_i,
    output logic [4:0]                 moves_left_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
`ifdef PUZZLE_BLANK_TRACK_EN
    ,
    input  logic [3:0]                 blank_init_i,
    output logic [3:0]                 blank_pos_o
`endif
);

    import puzzle_pkg::*;

    localparam int SH_W   = 2 * MAX_MOVES;
    localparam int WORD_W = CNT_W + SH_W;

    state_t             state_q;
    logic [IDX_W-1:0]   rom_addr_q;
    logic [SH_W-1:0]    shreg_q;
    logic [CNT_W-1:0]   moves_left_q;
    logic               move_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [CNT_W-1:0]   rom_cnt;
    logic               start_accept;
    logic               accept;
    logic               illegal;
    logic               bad_init;

    assign rom_cnt      = rom_data_i[WORD_W-1 -: CNT_W];
    assign start_accept = (state_q == ST_IDLE) && start_i;
    assign move_valid_o = move_valid_q && !illegal;
    assign move_dir_o   = shreg_q[SH_W-1 -: 2];
    assign accept       = move_valid_o && move_ready_i && !abort_i;

`ifdef PUZZLE_BLANK_TRACK_EN
    logic trk_illegal;

    puzzle_blank_tracker u_tracker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (start_accept),
        .init_i    (blank_init_i),
        .step_i    (accept),
        .dir_i     (dir_t'(move_dir_o)),
        .pos_o     (blank_pos_o),
        .illegal_o (trk_illegal)
    );

    assign illegal  = trk_illegal && move_valid_q;
    assign bad_init = blank_init_i > 4'd8;
`else
    assign illegal  = 1'b0;
    assign bad_init = 1'b0;
`endif

    // Outputs are registered alongside the state so they describe the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            shreg_q      <= '0;
            moves_left_q <= '0;
            move_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rom_addr_q <= pattern_idx_i;
                        busy_q     <= 1'b1;
                        if (int'(pattern_idx_i) >= N_PATTERNS || bad_init) begin
                            state_q      <= ST_ERR;
                            err_q        <= 1'b1;
                            moves_left_q <= '0;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        shreg_q <= rom_data_i[SH_W-1:0];
                        if (rom_cnt == '0) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            moves_left_q <= '0;
                        end else if (int'(rom_cnt) > MAX_MOVES) begin
                            state_q      <= ST_ERR;
                            err_q        <= 1'b1;
                            moves_left_q <= '0;
                        end else begin
                            state_q      <= ST_RUN;
                            move_valid_q <= 1'b1;
                            moves_left_q <= rom_cnt;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort beats both the handshake and the legality check.
                    if (abort_i) begin
                        state_q      <= ST_IDLE;
                        move_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (illegal) begin
                        state_q      <= ST_ERR;
                        err_q        <= 1'b1;
                        move_valid_q <= 1'b0;
                        moves_left_q <= '0;
                    end else if (move_ready_i) begin
                        shreg_q      <= {shreg_q[SH_W-3:0], 2'b00};
                        moves_left_q <= moves_left_q - CNT_W'(1);
                        if (moves_left_q == CNT_W'(1)) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            move_valid_q <= 1'b0;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    move_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr_o   = rom_addr_q;
    assign moves_left_o = moves_left_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_puzzle_move_sequencer.sv
// Scoreboard bench for puzzle_move_sequencer with a small behavioural solution ROM.
// Adds blank-tracking scenarios when PUZZLE_BLANK_TRACK_EN is defined.
module tb_puzzle_move_sequencer;

    localparam int IDX_W = 6;
    localparam int ROM_W = 45;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [IDX_W-1:0] pattern_idx_i;
    logic             abort_i;
    logic [IDX_W-1:0] rom_addr_o;
    logic [ROM_W-1:0] rom_data_i;
    logic             move_valid_o;
    logic [1:0]       move_dir_o;
    logic             move_ready_i;
    logic [4:0]       moves_left_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
`ifdef PUZZLE_BLANK_TRACK_EN
    logic [3:0]       blank_init_i;
    logic [3:0]       blank_pos_o;
`endif

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] dir;
        logic [4:0] ml;
        int         cyc;
    } exp_t;

    exp_t scoreboard[$];
    int   errorCount = 0;
    int   checkCount = 0;
    int   cycleCount = 0;

    puzzle_move_sequencer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pattern_idx_i (pattern_idx_i),
        .abort_i       (abort_i),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .move_valid_o  (move_valid_o),
        .move_dir_o    (move_dir_o),
        .move_ready_i  (move_ready_i),
        .moves_left_o  (moves_left_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
`ifdef PUZZLE_BLANK_TRACK_EN
        ,
        .blank_init_i  (blank_init_i),
        .blank_pos_o   (blank_pos_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycleCount++;

    // Hand-written ROM: 0 empty, 5 = up,left,down,right, 9 = left,up,right,down,
    // 7 has an oversized count, 59 is the last valid index with a single right move.
    function automatic logic [ROM_W-1:0] romWord(input logic [IDX_W-1:0] a);
        case (a)
            6'd0:    return {5'd0, 40'b0};
            6'd5:    return {5'd4, 8'b11_10_00_01, 32'b0};
            6'd7:    return {5'd21, 40'b0};
            6'd9:    return {5'd4, 8'b10_11_01_00, 32'b0};
            6'd59:   return {5'd1, 2'b01, 38'b0};
            default: return '0;
        endcase
    endfunction

    assign rom_data_i = romWord(rom_addr_o);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cycleCount);
        end
    endtask

    task automatic expectMove(input logic [1:0] dir, input logic [4:0] ml, input int c);
        scoreboard.push_back('{kind: 2'd0, dir: dir, ml: ml, cyc: c});
    endtask

    task automatic expectEnd(input logic [1:0] kind, input int c);
        scoreboard.push_back('{kind: kind, dir: 2'b00, ml: 5'd0, cyc: c});
    endtask

    task automatic handleEvent(input logic [1:0] kind, input logic [1:0] dir, input logic [4:0] ml);
        exp_t  e;
        string nm;
        if (scoreboard.size() == 0) begin
            checkOutput("unexpected_event_kind", 64'(kind), 64'd99);
            return;
        end
        e = scoreboard.pop_front();
        if (e.kind == 2'd0)      nm = "move";
        else if (e.kind == 2'd1) nm = "done";
        else                     nm = "err";
        checkOutput(nm, {8'(kind), 6'b0, dir, 3'b0, ml, 32'(cycleCount)},
                        {8'(e.kind), 6'b0, e.dir, 3'b0, e.ml, 32'(e.cyc)});
    endtask

    // Monitor: every accepted move, done or err pulse is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (move_valid_o && move_ready_i && !abort_i) begin
                handleEvent(2'd0, move_dir_o, moves_left_o);
            end else if (move_valid_o && !move_ready_i && !abort_i) begin
                if (scoreboard.size() > 0 && scoreboard[0].kind == 2'd0)
                    checkOutput("stall_hold_dir", 64'(move_dir_o), 64'(scoreboard[0].dir));
                else
                    checkOutput("unexpected_valid", 64'(move_valid_o), 64'd0);
            end
            if (done_o) handleEvent(2'd1, 2'b00, moves_left_o);
            if (err_o)  handleEvent(2'd2, 2'b00, moves_left_o);
        end
    end

    task automatic applyStimulus(input logic [IDX_W-1:0] idx, output int n);
        pattern_idx_i = idx;
        start_i       = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        n       = cycleCount;
    endtask

    task automatic waitCyc(input int t);
        while (cycleCount < t) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic waitIdle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy_o) return;
            @(posedge clk_i); #1;
        end
        checkOutput("idle_timeout_busy", 64'(busy_o), 64'd0);
    endtask

    task automatic runPattern5();
        int n;
        applyStimulus(6'd5, n);
        expectMove(2'b11, 5'd4, n + 1);
        expectMove(2'b10, 5'd3, n + 2);
        expectMove(2'b00, 5'd2, n + 3);
        expectMove(2'b01, 5'd1, n + 4);
        expectEnd(2'd1, n + 5);
        checkOutput("busy_in_fetch", 64'(busy_o), 64'd1);
        waitIdle(20);
        checkOutput("moves_left_after_done", 64'(moves_left_o), 64'd0);
    endtask

    initial begin
        int n;
        rst_i         = 1'b1;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        move_ready_i  = 1'b1;
        pattern_idx_i = '0;
`ifdef PUZZLE_BLANK_TRACK_EN
        blank_init_i  = 4'd4;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_rom_addr", 64'(rom_addr_o), 64'd0);
        checkOutput("rst_move_valid", 64'(move_valid_o), 64'd0);
        checkOutput("rst_move_dir", 64'(move_dir_o), 64'd0);
        checkOutput("rst_moves_left", 64'(moves_left_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done_err", 64'({done_o, err_o}), 64'd0);
`ifdef PUZZLE_BLANK_TRACK_EN
        checkOutput("rst_blank_pos", 64'(blank_pos_o), 64'd4);
`endif
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        $display("[TB] pattern 5 full replay");
        runPattern5();

        $display("[TB] pattern 0 zero count");
        applyStimulus(6'd0, n);
        expectEnd(2'd1, n + 1);
        waitIdle(20);

        $display("[TB] bad index 60");
        applyStimulus(6'd60, n);
        expectEnd(2'd2, n);
        checkOutput("bad_idx_rom_addr", 64'(rom_addr_o), 64'd60);
        checkOutput("bad_idx_moves_left", 64'(moves_left_o), 64'd0);
        waitIdle(20);

        $display("[TB] bad count pattern 7");
        applyStimulus(6'd7, n);
        expectEnd(2'd2, n + 1);
        waitIdle(20);

        $display("[TB] last index 59 single move");
        applyStimulus(6'd59, n);
        expectMove(2'b01, 5'd1, n + 1);
        expectEnd(2'd1, n + 2);
        waitIdle(20);

        $display("[TB] pattern 9 with stalled second move and ignored start");
        applyStimulus(6'd9, n);
        expectMove(2'b10, 5'd4, n + 1);
        expectMove(2'b11, 5'd3, n + 5);
        expectMove(2'b01, 5'd2, n + 6);
        expectMove(2'b00, 5'd1, n + 7);
        expectEnd(2'd1, n + 8);
        waitCyc(n + 2);
        move_ready_i  = 1'b0;
        start_i       = 1'b1;
        pattern_idx_i = 6'd0;
        waitCyc(n + 3);
        start_i = 1'b0;
        waitCyc(n + 5);
        move_ready_i = 1'b1;
        waitIdle(20);
        checkOutput("p9_moves_left_end", 64'(moves_left_o), 64'd0);

        $display("[TB] abort on third move");
        applyStimulus(6'd5, n);
        expectMove(2'b11, 5'd4, n + 1);
        expectMove(2'b10, 5'd3, n + 2);
        waitCyc(n + 3);
        abort_i = 1'b1;
        waitCyc(n + 4);
        abort_i = 1'b0;
        checkOutput("abort_move_valid", 64'(move_valid_o), 64'd0);
        checkOutput("abort_busy", 64'(busy_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("abort_sb_drained", 64'(scoreboard.size()), 64'd0);
        runPattern5();

        $display("[TB] reset mid-run");
        applyStimulus(6'd5, n);
        expectMove(2'b11, 5'd4, n + 1);
        waitCyc(n + 2);
        rst_i = 1'b1;
        waitCyc(n + 3);
        rst_i = 1'b0;
        checkOutput("rst_mid_move_valid", 64'(move_valid_o), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_mid_moves_left", 64'(moves_left_o), 64'd0);
        checkOutput("rst_mid_rom_addr", 64'(rom_addr_o), 64'd0);
        runPattern5();

`ifdef PUZZLE_BLANK_TRACK_EN
        begin
            int expPos [6] = '{4, 4, 1, 0, 3, 4};
            $display("[TB] blank tracking from centre");
            blank_init_i = 4'd4;
            applyStimulus(6'd5, n);
            expectMove(2'b11, 5'd4, n + 1);
            expectMove(2'b10, 5'd3, n + 2);
            expectMove(2'b00, 5'd2, n + 3);
            expectMove(2'b01, 5'd1, n + 4);
            expectEnd(2'd1, n + 5);
            for (int i = 0; i < 6; i++) begin
                waitCyc(n + i);
                checkOutput("blank_pos_seq", 64'(blank_pos_o), 64'(expPos[i]));
            end
            waitIdle(20);

            $display("[TB] illegal first move from corner");
            blank_init_i = 4'd0;
            applyStimulus(6'd5, n);
            expectEnd(2'd2, n + 2);
            waitCyc(n + 1);
            checkOutput("illegal_move_valid", 64'(move_valid_o), 64'd0);
            waitIdle(20);
            checkOutput("illegal_blank_pos", 64'(blank_pos_o), 64'd0);
            blank_init_i = 4'd4;
        end
`endif

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("sb_empty", 64'(scoreboard.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        errorCount++;
        $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
